// File: rtl/fifo_burst_reader.sv
// Drains an external FIFO in fixed-length bursts onto a valid/ready stream with last marker.
// Optional timeout flush of partial bursts: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 8,
    parameter int  BURST_LEN  = 4,
    parameter int  TIMEOUT    = 16,
    parameter type dtype      = logic [DATA_WIDTH-1:0],
    parameter int  ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_full_i,
    input  logic [ADDR_DEPTH-1:0] fifo_usage_i,
    input  dtype                  fifo_data_i,
    output logic                  fifo_pop_o,
    output dtype                  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int LW = ADDR_DEPTH + 1;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, BURST} state_t;
`endif

    state_t          state;
    logic [LW-1:0]   level;
    logic [LW-1:0]   remaining;
    logic            slot_free;
    logic            burst_ready;

    // usage wraps to 0 when full, so full overrides it
    assign level       = fifo_full_i ? LW'(DEPTH) : {1'b0, fifo_usage_i};
    assign slot_free   = !valid_o || ready_i;
    assign burst_ready = (level >= LW'(BURST_LEN));
    assign fifo_pop_o  = (state != IDLE) && slot_free && !fifo_empty_i && !clr_i;
    assign busy_o      = (state != IDLE) || valid_o;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] to_cnt;
    logic          to_fire;

    assign to_fire = (to_cnt == TW'(TIMEOUT - 1)) && !fifo_empty_i && !burst_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt <= '0;
        end else if (clr_i || state != IDLE || fifo_empty_i || burst_ready || to_fire) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT - 1)) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            remaining <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
        end else if (clr_i) begin
            state     <= IDLE;
            remaining <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
        end else begin
            // a pop refills the register in the same edge the held beat leaves
            if (fifo_pop_o) begin
                data_o    <= fifo_data_i;
                valid_o   <= 1'b1;
                last_o    <= (remaining == LW'(1));
                remaining <= remaining - LW'(1);
            end else if (ready_i) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (burst_ready) begin
                        state     <= BURST;
                        remaining <= LW'(BURST_LEN);
                    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                    else if (to_fire) begin
                        state     <= FLUSH;
                        remaining <= level;
                    end
`endif
                end
                default: begin
                    if (fifo_pop_o && remaining == LW'(1))
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule
